tlc_signal_monitor: RTL and testbench
=====================================

Name: tlc_signal_monitor

Overview:
- Conflict monitor sitting on the output side of the traffic-light controller.
- Consumes the two 2-bit lamp buses (highwaySignal, farmSignal) exactly as the controller drives them to the lamps.
- Independently checks encoding, mutual exclusion, legal phase order and dwell times, then latches a sticky fault with a cause code.
- Used on-board (fault LED / JB debug header) and as a scoreboard in the controller testbench.

Parameters:
- CNT_W, 31, width of dwell counter; saturates at all-ones.
- MIN_GREEN_CYC, 150000000, minimum cycles either road may show green.
- YELLOW_CYC, 150000000, nominal yellow duration in cycles.
- ALLRED_CYC, 50000000, minimum all-red clearance in cycles.
- TOL_CYC, 2, +/- tolerance applied to yellow duration and the all-red minimum.

Ports:
- Clk, input, 1, system clock.
- Rst, input, 1, asynchronous, active-low reset.
- highwaySignal, input, 2, highway lamp code.
- farmSignal, input, 2, farm lamp code.
- FaultClr, input, 1, synchronous clear of latched fault (ignored while a fault condition persists).
- Fault, output, 1, sticky fault flag.
- FaultCode, output, 3, cause of the first fault.
- CycleDone, output, 1, one-cycle pulse when a full legal cycle completes (highway green -> ... -> farm -> back to highway green).
- MonState, output, 3, current monitor state, for the debug header.

Behaviour:
- Lamp encoding (shared package): GREEN=2'b00, YELLOW=2'b01, RED=2'b10, 2'b11 illegal.
- Input stage: both buses registered once (samp). The previous sample is also held (prev).
- Change event: samp != prev.
- Dwell counter: cleared to 1 on a change event, else increments; saturates at all-ones.
- Checks are evaluated on samp/prev/dwell. Fault and FaultCode register one cycle after samp updates, so they are visible 2 Clk edges after the offending input change.
- Reset (Rst low, async): samp and prev = {RED,RED}, dwell=0, state=M_INIT, Fault=0, FaultCode=3'd0, CycleDone=0.
- States:
  - M_INIT: wait for the first legal green on either road. Any conflict or illegal code here still faults.
  - M_HWY: highway G or Y, farm R.
  - M_CLR_F: all-red after highway yellow.
  - M_FARM: farm G or Y, highway R.
  - M_CLR_H: all-red after farm yellow.
  - M_FAULT: entered on any fault.
- Transitions:
  - M_INIT -> M_HWY or M_FARM on the first green.
  - M_HWY -> M_CLR_F when highway Y->R.
  - M_CLR_F -> M_FARM when farm R->G.
  - M_FARM -> M_CLR_H when farm Y->R.
  - M_CLR_H -> M_HWY when highway R->G; CycleDone pulses on this entry.
- Fault codes (priority high to low on the same cycle):
  - 1 illegal code 2'b11 on either bus.
  - 2 conflict: both buses non-RED.
  - 3 illegal transition: G->R, Y->G, R->Y, or a green on the road that did not just clear.
  - 4 green too short: G->Y with dwell < MIN_GREEN_CYC.
  - 5 yellow timing: Y->R with dwell outside YELLOW_CYC +/- TOL_CYC.
  - 6 all-red too short: R->G with all-red dwell < ALLRED_CYC - TOL_CYC.
- Fault handling:
  - Sticky: first FaultCode is held; later faults do not overwrite it.
  - In M_FAULT, FaultClr=1 clears Fault and FaultCode and returns to M_INIT only if the current samp is fault-free (codes 1/2 inactive). Otherwise FaultClr is ignored.
  - Fault and CycleDone are never high together; fault wins.
- Other boundaries:
  - Yellow exactly at YELLOW_CYC +/- TOL_CYC passes (inclusive limits).
  - Simultaneous change on both buses in one cycle is checked as a single transition.
  - Dwell saturation never wraps. A saturated yellow therefore faults (code 5).
  - Reset asserted mid-cycle returns to M_INIT with no fault reported.

Decomposition:
- Package tlc_pkg holds:
  - lamp code constants GREEN/YELLOW/RED;
  - monitor state encodings M_INIT..M_FAULT (3-bit);
  - fault code constants F_NONE..F_ALLRED.
- The controller FSM shares the same lamp constants.
- One sub-module, tlc_dwell_counter: saturating CNT_W counter with synchronous load-to-1 on change and async active-low reset.
- Transition and timing checks stay in the top.

Test Plan (MIN_GREEN_CYC=10, YELLOW_CYC=6, ALLRED_CYC=3, TOL_CYC=1):
- Legal cycle: HG 10, HY 6, RR 3, FG 10, FY 6, RR 3, HG -> CycleDone single pulse 1 cycle after the final HG is sampled; Fault stays 0.
- Conflict: drive highway=GREEN, farm=YELLOW -> Fault=1, FaultCode=2 two edges later, state M_FAULT. FaultClr while the conflict persists -> stays faulted.
- Yellow timing: yellow held 4 cycles -> FaultCode=5. Separate run with 5 and with 7 cycles -> no fault.
- Skip yellow: highway G (12 cycles) -> R directly -> FaultCode=3.
- Illegal code 2'b11 on farm during M_CLR_F, same cycle as a yellow timing error -> FaultCode=1 (priority). FaultClr after legal RR -> Fault=0, state M_INIT.
- Async reset: pull Rst low mid-yellow between edges -> Fault=0, MonState=M_INIT immediately. Release and replay the legal cycle -> passes.

Source files
------------

// File: rtl/tlc_pkg.sv
// Purpose: shared lamp codes, monitor state encodings and fault cause codes.
// Latency: n/a (constants and one pure helper function).
// Backpressure: n/a.
package tlc_pkg;

    // Lamp codes as driven by the controller onto each road's lamp bus.
    localparam logic [1:0] GREEN    = 2'b00;
    localparam logic [1:0] YELLOW   = 2'b01;
    localparam logic [1:0] RED      = 2'b10;
    localparam logic [1:0] LAMP_BAD = 2'b11;

    // Monitor states, exported unchanged on the debug header.
    typedef enum logic [2:0] {
        M_INIT  = 3'd0,
        M_HWY   = 3'd1,
        M_CLR_F = 3'd2,
        M_FARM  = 3'd3,
        M_CLR_H = 3'd4,
        M_FAULT = 3'd5
    } mon_state_e;

    // Fault causes; lower non-zero value wins when several fire together.
    localparam logic [2:0] F_NONE     = 3'd0;
    localparam logic [2:0] F_ILLEGAL  = 3'd1;
    localparam logic [2:0] F_CONFLICT = 3'd2;
    localparam logic [2:0] F_TRANS    = 3'd3;
    localparam logic [2:0] F_GREEN    = 3'd4;
    localparam logic [2:0] F_YELLOW   = 3'd5;
    localparam logic [2:0] F_ALLRED   = 3'd6;

    // A lamp may only step G->Y->R->G; these three moves skip or reverse it.
    function automatic logic lamp_bad_step(input logic [1:0] from, input logic [1:0] to);
        return ((from == GREEN)  && (to == RED))    ||
               ((from == YELLOW) && (to == GREEN))  ||
               ((from == RED)    && (to == YELLOW));
    endfunction

endpackage

// File: rtl/tlc_dwell_counter.sv
// Purpose: counts how many cycles the sampled lamp pair has been stable.
// Latency: load takes effect on the next edge; saturates at all-ones, never wraps.
// Backpressure: none; free-running.
module tlc_dwell_counter #(
    parameter int unsigned CNT_W = 31
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Restart at 1 on a lamp change, otherwise count up and stick at the top.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tlc_signal_monitor.sv
// Purpose: watches both lamp buses and latches the first conflict/order/timing fault.
// Latency: Fault/FaultCode/CycleDone appear 2 edges after the lamp change.
// Backpressure: none; observes only. FaultClr is ignored while a level fault persists.
module tlc_signal_monitor
    import tlc_pkg::*;
#(
    parameter int unsigned CNT_W         = 31,
    parameter int unsigned MIN_GREEN_CYC = 150000000,
    parameter int unsigned YELLOW_CYC    = 150000000,
    parameter int unsigned ALLRED_CYC    = 50000000,
    parameter int unsigned TOL_CYC       = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] highwaySignal,
    input  logic [1:0] farmSignal,
    input  logic       FaultClr,
    output logic       Fault,
    output logic [2:0] FaultCode,
    output logic       CycleDone,
    output logic [2:0] MonState
);

    localparam logic [CNT_W-1:0] MIN_GREEN = CNT_W'(MIN_GREEN_CYC);
    localparam logic [CNT_W-1:0] YEL_LO    = CNT_W'(YELLOW_CYC - TOL_CYC);
    localparam logic [CNT_W-1:0] YEL_HI    = CNT_W'(YELLOW_CYC + TOL_CYC);
    localparam logic [CNT_W-1:0] ALLRED_LO = CNT_W'(ALLRED_CYC - TOL_CYC);

    logic [3:0]       samp_q;
    logic [3:0]       prev_q;
    logic [1:0]       hwy_s, farm_s, hwy_p, farm_p;
    logic             change;
    logic [CNT_W-1:0] dwell;

    mon_state_e       state_q;
    logic             fault_q;
    logic [2:0]       code_q;
    logic             cycle_done_q;

    logic             illegal, conflict, hwy_go, farm_go, timed;
    logic             bad_order, to_yellow, to_red;
    logic [2:0]       code_d;

    // Register the lamp pair once and keep the previous sample for edge detection.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            samp_q <= {RED, RED};
            prev_q <= {RED, RED};
        end else begin
            samp_q <= {highwaySignal, farmSignal};
            prev_q <= samp_q;
        end
    end

    assign hwy_s  = samp_q[3:2];
    assign farm_s = samp_q[1:0];
    assign hwy_p  = prev_q[3:2];
    assign farm_p = prev_q[1:0];
    assign change = (samp_q != prev_q);

    // At a change event the counter still holds the duration of the old lamp pair.
    tlc_dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk_i  (Clk),
        .rst_ni (Rst),
        .load_i (change),
        .cnt_o  (dwell)
    );

    // Evaluate every check on the sampled pair and pick the highest-priority cause.
    always_comb begin
        illegal  = (hwy_s == LAMP_BAD) || (farm_s == LAMP_BAD);
        conflict = (hwy_s != RED) && (farm_s != RED);
        hwy_go   = (hwy_p == RED) && (hwy_s == GREEN);
        farm_go  = (farm_p == RED) && (farm_s == GREEN);
        // Timing is only meaningful once a phase has been locked onto.
        timed    = state_q inside {M_HWY, M_CLR_F, M_FARM, M_CLR_H};

        // A road may go green only out of its own clearance (or as the first green).
        bad_order = lamp_bad_step(hwy_p, hwy_s) || lamp_bad_step(farm_p, farm_s) ||
                    (hwy_go  && !(state_q inside {M_CLR_H, M_INIT})) ||
                    (farm_go && !(state_q inside {M_CLR_F, M_INIT}));
        to_yellow = ((hwy_p == GREEN)  && (hwy_s == YELLOW)) ||
                    ((farm_p == GREEN) && (farm_s == YELLOW));
        to_red    = ((hwy_p == YELLOW)  && (hwy_s == RED)) ||
                    ((farm_p == YELLOW) && (farm_s == RED));

        code_d = F_NONE;
        if (illegal) begin
            code_d = F_ILLEGAL;
        end else if (conflict) begin
            code_d = F_CONFLICT;
        end else if (bad_order) begin
            code_d = F_TRANS;
        end else if (timed && to_yellow && (dwell < MIN_GREEN)) begin
            code_d = F_GREEN;
        end else if (timed && to_red && ((dwell < YEL_LO) || (dwell > YEL_HI))) begin
            code_d = F_YELLOW;
        end else if (timed && (hwy_go || farm_go) && (dwell < ALLRED_LO)) begin
            code_d = F_ALLRED;
        end
    end

    // Phase tracker with sticky fault latch and cycle-complete pulse.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= M_INIT;
            fault_q      <= 1'b0;
            code_q       <= F_NONE;
            cycle_done_q <= 1'b0;
        end else begin
            cycle_done_q <= 1'b0;
            if (state_q == M_FAULT) begin
                // Only release once the lamps themselves look sane again.
                if (FaultClr && !illegal && !conflict) begin
                    state_q <= M_INIT;
                    fault_q <= 1'b0;
                    code_q  <= F_NONE;
                end
            end else if (code_d != F_NONE) begin
                state_q <= M_FAULT;
                fault_q <= 1'b1;
                code_q  <= code_d;
            end else begin
                case (state_q)
                    M_INIT: begin
                        if (hwy_s == GREEN) begin
                            state_q <= M_HWY;
                        end else if (farm_s == GREEN) begin
                            state_q <= M_FARM;
                        end
                    end
                    M_HWY: begin
                        if ((hwy_p == YELLOW) && (hwy_s == RED)) begin
                            state_q <= M_CLR_F;
                        end
                    end
                    M_CLR_F: begin
                        if (farm_go) begin
                            state_q <= M_FARM;
                        end
                    end
                    M_FARM: begin
                        if ((farm_p == YELLOW) && (farm_s == RED)) begin
                            state_q <= M_CLR_H;
                        end
                    end
                    M_CLR_H: begin
                        if (hwy_go) begin
                            state_q      <= M_HWY;
                            cycle_done_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= M_INIT;
                    end
                endcase
            end
        end
    end

    assign Fault     = fault_q;
    assign FaultCode = code_q;
    assign CycleDone = cycle_done_q;
    assign MonState  = state_q;

endmodule

// File: tb/tb_tlc_signal_monitor.sv
module tb_tlc_signal_monitor;
    import tlc_pkg::*;

    localparam int CNT_W = 8;
    localparam int MIN_G = 10;
    localparam int YEL   = 6;
    localparam int AR    = 3;
    localparam int TOL   = 1;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [1:0] hwy_drv = RED;
    logic [1:0] farm_drv = RED;
    logic       FaultClr = 1'b0;
    logic       Fault;
    logic [2:0] FaultCode;
    logic       CycleDone;
    logic [2:0] MonState;

    int checks = 0;
    int failures = 0;

    // Reference model: works on whole lamp segments (value + hold length).
    bit         m_faulted;
    logic [2:0] m_code;
    bit         m_track;
    int         m_owner;      // road that last held right of way: 1 highway, 2 farm
    logic [1:0] m_ph, m_pf;
    int         m_dur;
    bit         m_pulse_now;
    int         m_pulses;
    int         seen_pulses;
    int         both_high;

    tlc_signal_monitor #(
        .CNT_W(CNT_W), .MIN_GREEN_CYC(MIN_G), .YELLOW_CYC(YEL),
        .ALLRED_CYC(AR), .TOL_CYC(TOL)
    ) dut (
        .Clk(Clk), .Rst(Rst), .highwaySignal(hwy_drv), .farmSignal(farm_drv),
        .FaultClr(FaultClr), .Fault(Fault), .FaultCode(FaultCode),
        .CycleDone(CycleDone), .MonState(MonState)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // The lamp cycle is G -> Y -> R -> G; anything else between colours is out of order.
    function automatic logic [1:0] succ(input logic [1:0] c);
        case (c)
            GREEN:   return YELLOW;
            YELLOW:  return RED;
            RED:     return GREEN;
            default: return c;
        endcase
    endfunction

    function automatic bit step_ok(input logic [1:0] a, input logic [1:0] b);
        return (a == b) || (b == succ(a)) || (a == LAMP_BAD) || (b == LAMP_BAD);
    endfunction

    task automatic model_reset();
        m_faulted = 0; m_code = F_NONE; m_track = 0; m_owner = 0;
        m_ph = RED; m_pf = RED; m_dur = 0; m_pulse_now = 0;
        m_pulses = 0; seen_pulses = 0; both_high = 0;
    endtask

    task automatic model_apply(input logic [1:0] h, input logic [1:0] f, input int len);
        int d;
        logic [2:0] c;
        bit hgo, fgo, rr_prev, gy, yr;
        m_pulse_now = 0;
        if (h == m_ph && f == m_pf) begin
            m_dur += len;
            return;
        end
        d       = (m_dur > SAT) ? SAT : m_dur;
        hgo     = (m_ph == RED) && (h == GREEN);
        fgo     = (m_pf == RED) && (f == GREEN);
        rr_prev = (m_ph == RED) && (m_pf == RED);
        gy      = (m_ph == GREEN && h == YELLOW) || (m_pf == GREEN && f == YELLOW);
        yr      = (m_ph == YELLOW && h == RED) || (m_pf == YELLOW && f == RED);
        c = F_NONE;
        if (h == LAMP_BAD || f == LAMP_BAD) c = F_ILLEGAL;
        else if (h != RED && f != RED) c = F_CONFLICT;
        else if (!step_ok(m_ph, h) || !step_ok(m_pf, f) ||
                 (m_track && hgo && (!rr_prev || m_owner == 1)) ||
                 (m_track && fgo && (!rr_prev || m_owner == 2))) c = F_TRANS;
        else if (m_track && gy && d < MIN_G) c = F_GREEN;
        else if (m_track && yr && (d < YEL - TOL || d > YEL + TOL)) c = F_YELLOW;
        else if (m_track && (hgo || fgo) && d < AR - TOL) c = F_ALLRED;

        if (!m_faulted && c != F_NONE) begin
            m_faulted = 1;
            m_code = c;
        end else if (!m_faulted) begin
            if (m_track && hgo && m_owner == 2) begin
                m_pulse_now = 1;
                m_pulses++;
            end
            if (h == GREEN) begin m_track = 1; m_owner = 1; end
            else if (f == GREEN) begin m_track = 1; m_owner = 2; end
        end
        m_ph = h; m_pf = f; m_dur = len;
    endtask

    task automatic tick_count();
        @(posedge Clk); @(negedge Clk);
        if (CycleDone === 1'b1) seen_pulses++;
        if (CycleDone === 1'b1 && Fault === 1'b1) both_high++;
    endtask

    // Drive one lamp pair for len cycles; check outputs 2 edges after the change.
    task automatic seg(input logic [1:0] h, input logic [1:0] f, input int len);
        model_apply(h, f, len);
        hwy_drv = h; farm_drv = f;
        for (int i = 0; i < len; i++) begin
            tick_count();
            if (i == 1) begin
                check("fault", Fault, m_faulted);
                check("code", FaultCode, m_code);
                check("cycdone", CycleDone, m_pulse_now);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick_count();
        m_dur += n;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b0; hwy_drv = RED; farm_drv = RED; FaultClr = 1'b0;
        @(negedge Clk); @(negedge Clk);
        Rst = 1'b1;
        model_reset();
    endtask

    task automatic legal_cycle();
        seg(GREEN, RED, 10); seg(YELLOW, RED, 6); seg(RED, RED, 3);
        seg(RED, GREEN, 10); seg(RED, YELLOW, 6); seg(RED, RED, 3);
        seg(GREEN, RED, 4);
    endtask

    task automatic pulse_check(input string tag);
        idle(2);
        check(tag, seen_pulses, m_pulses);
        check("excl", both_high, 0);
    endtask

    initial begin
        logic [1:0] rh, rf;
        int ph;
        model_reset();
        #2 Rst = 1'b0;
        #1;
        check("rst_fault", Fault, 0);
        check("rst_code", FaultCode, F_NONE);
        check("rst_cycdone", CycleDone, 0);
        check("rst_state", MonState, M_INIT);
        @(negedge Clk); Rst = 1'b1; model_reset();

        // Full legal cycle
        legal_cycle();
        check("legal_state", MonState, M_HWY);
        pulse_check("legal_pulses");
        check("legal_npulse", seen_pulses, 1);

        // Conflict, then clear attempt while it persists
        do_reset();
        seg(GREEN, RED, 10); seg(GREEN, YELLOW, 3);
        check("confl_state", MonState, M_FAULT);
        check("confl_code", FaultCode, F_CONFLICT);
        FaultClr = 1'b1; tick_count(); FaultClr = 1'b0; m_dur += 1;
        check("confl_clr_fault", Fault, 1);
        check("confl_clr_state", MonState, M_FAULT);

        // Yellow timing: short, both inclusive limits, saturated
        do_reset(); seg(GREEN, RED, 10); seg(YELLOW, RED, 4); seg(RED, RED, 3);
        check("yel4_code", FaultCode, F_YELLOW);
        do_reset(); seg(GREEN, RED, 10); seg(YELLOW, RED, 5); seg(RED, RED, 3);
        check("yel5_state", MonState, M_CLR_F);
        do_reset(); seg(GREEN, RED, 10); seg(YELLOW, RED, 7); seg(RED, RED, 3);
        check("yel7_fault", Fault, 0);
        do_reset(); seg(GREEN, RED, 10); seg(YELLOW, RED, SAT + 1 + YEL); seg(RED, RED, 3);
        check("yel_sat_code", FaultCode, F_YELLOW);

        // Skipped yellow
        do_reset(); seg(GREEN, RED, 12); seg(RED, RED, 3);
        check("skip_code", FaultCode, F_TRANS);

        // Illegal code together with a short yellow, then clear on a clean all-red
        do_reset(); seg(GREEN, RED, 10); seg(YELLOW, RED, 4); seg(RED, LAMP_BAD, 3);
        check("prio_code", FaultCode, F_ILLEGAL);
        seg(RED, RED, 3);
        FaultClr = 1'b1; tick_count(); FaultClr = 1'b0;
        m_faulted = 0; m_code = F_NONE; m_track = 0; m_dur += 1;
        check("clr_fault", Fault, 0);
        check("clr_code", FaultCode, F_NONE);
        check("clr_state", MonState, M_INIT);

        // Async reset in the middle of a (faulted) yellow, then replay
        do_reset(); seg(GREEN, RED, 5); seg(YELLOW, RED, 3);
        check("short_green", FaultCode, F_GREEN);
        #2 Rst = 1'b0;
        #1;
        check("async_fault", Fault, 0);
        check("async_state", MonState, M_INIT);
        hwy_drv = RED; farm_drv = RED;
        @(negedge Clk); Rst = 1'b1; model_reset();
        legal_cycle();
        check("replay_fault", Fault, 0);
        pulse_check("replay_pulses");

        // Randomized phase sequences with occasional corrupt lamp pairs
        for (int ep = 0; ep < 16; ep++) begin
            do_reset();
            ph = ($urandom_range(0, 1) == 0) ? 0 : 3;
            for (int s = 0; s < 14; s++) begin
                if ($urandom_range(0, 9) == 0) begin
                    rh = 2'($urandom); rf = 2'($urandom);
                    seg(rh, rf, $urandom_range(1, 4));
                end else begin
                    case (ph)
                        0: seg(GREEN, RED, $urandom_range(9, 14));
                        1: seg(YELLOW, RED, ($urandom_range(0, 1) == 0) ? YEL : $urandom_range(4, 8));
                        2: seg(RED, RED, $urandom_range(1, 4));
                        3: seg(RED, GREEN, $urandom_range(9, 14));
                        4: seg(RED, YELLOW, ($urandom_range(0, 1) == 0) ? YEL : $urandom_range(4, 8));
                        default: seg(RED, RED, $urandom_range(1, 4));
                    endcase
                    ph = (ph + 1) % 6;
                end
            end
            pulse_check("rand_pulses");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
